// File: rtl/aes_encrypt_core_if.sv
// Load/result bus of the iterative AES encryptor; same shape as the decrypt block's bus.
interface aes_encrypt_core_if #(
  parameter int unsigned Nk = 4
);
  logic             load;
  logic [32*Nk-1:0] key;
  logic [127:0]     pt;
  logic             ct_valid;
  logic [127:0]     ct;

  modport master (output load, key, pt, input ct_valid, ct);
  modport slave  (input load, key, pt, output ct_valid, ct);
endinterface

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/192/256 encryptor: one key-schedule word per cycle, then one round per cycle.
// Optional busy output enabled by defining AES_ENC_BUSY_OUT_EN.
module aes_encrypt_core #(
  parameter int unsigned Nk = 4
) (
  input  logic clk,
  input  logic rst,
  aes_encrypt_core_if.slave bus
`ifdef AES_ENC_BUSY_OUT_EN
  ,
  output logic busy
`endif
);
  localparam int unsigned Nr       = Nk + 6;
  localparam int unsigned NumWords = 4 * (Nr + 1);
  localparam int unsigned IdxW     = $clog2(NumWords);
  localparam int unsigned RndW     = $clog2(Nr + 1);

  typedef enum logic [1:0] {StIdle, StKey, StRound, StDone} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 by an addition chain, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a12, t, inv;
    a2  = gf_mul(a, a);
    a3  = gf_mul(a2, a);
    t   = gf_mul(a3, a3);
    a12 = gf_mul(t, t);
    t   = gf_mul(a12, a3);
    for (int k = 0; k < 4; k++) t = gf_mul(t, t);
    t   = gf_mul(t, a12);
    inv = gf_mul(t, a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    for (int k = 0; k < 4; k++) o[8*k +: 8] = sbox(w[8*k +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = sbox(s[8*(4*((c+r)%4)+r) +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  state_e          state_q, state_d;
  logic [IdxW-1:0] i_q, i_d;
  logic [RndW-1:0] round_q, round_d;
  logic [2:0]      kmod_q, kmod_d;
  logic [7:0]      rcon_q, rcon_d;
  logic [127:0]    st_q, st_d;
  logic [127:0]    ct_q, ct_d;
  logic            ct_valid_q, ct_valid_d;
  logic [31:0]     w_q [NumWords];
  logic [31:0]     w_d [NumWords];

  logic [31:0]     temp;
  logic [IdxW-1:0] rk_idx;
  logic [127:0]    rk, sr;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    round_d    = round_q;
    kmod_d     = kmod_q;
    rcon_d     = rcon_q;
    st_d       = st_q;
    ct_d       = ct_q;
    ct_valid_d = ct_valid_q;
    w_d        = w_q;
    temp       = w_q[i_q - IdxW'(1)];
    rk_idx     = IdxW'({round_q, 2'b00});
    rk         = {w_q[rk_idx + IdxW'(3)], w_q[rk_idx + IdxW'(2)],
                  w_q[rk_idx + IdxW'(1)], w_q[rk_idx]};
    sr         = sub_shift(st_q);

    // Load wins in every state, aborting any operation in flight.
    if (bus.load) begin
      for (int j = 0; j < Nk; j++) w_d[j] = bus.key[32*j +: 32];
      st_d       = bus.pt;
      ct_valid_d = 1'b0;
      i_d        = IdxW'(Nk);
      kmod_d     = 3'd0;
      rcon_d     = 8'h01;
      round_d    = '0;
      state_d    = StKey;
    end else begin
      unique case (state_q)
        StKey: begin
          if (kmod_q == 3'd0) begin
            temp   = sub_word({temp[7:0], temp[31:8]}) ^ {24'h0, rcon_q};
            rcon_d = xtime(rcon_q);
          end else if (Nk == 8 && kmod_q == 3'd4) begin
            temp = sub_word(temp);
          end
          w_d[i_q] = w_q[i_q - IdxW'(Nk)] ^ temp;
          kmod_d   = (kmod_q == 3'(Nk - 1)) ? 3'd0 : kmod_q + 3'd1;
          i_d      = i_q + IdxW'(1);
          if (i_q == IdxW'(NumWords - 1)) begin
            round_d = '0;
            state_d = StRound;
          end
        end
        StRound: begin
          round_d = round_q + RndW'(1);
          if (round_q == '0) begin
            st_d = st_q ^ rk;
          end else if (round_q == RndW'(Nr)) begin
            st_d       = sr ^ rk;
            ct_d       = sr ^ rk;
            ct_valid_d = 1'b1;
            state_d    = StDone;
          end else begin
            st_d = mix_columns(sr) ^ rk;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      i_q        <= '0;
      round_q    <= '0;
      kmod_q     <= '0;
      rcon_q     <= '0;
      st_q       <= '0;
      ct_q       <= '0;
      ct_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      round_q    <= round_d;
      kmod_q     <= kmod_d;
      rcon_q     <= rcon_d;
      st_q       <= st_d;
      ct_q       <= ct_d;
      ct_valid_q <= ct_valid_d;
    end
  end

  // Schedule contents need no reset.
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  assign bus.ct       = ct_q;
  assign bus.ct_valid = ct_valid_q;

`ifdef AES_ENC_BUSY_OUT_EN
  assign busy = (state_q == StKey) || (state_q == StRound);
`endif

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed bench for aes_encrypt_core: FIPS-197 vectors for Nk=4/6/8, latency, reload, reset.
module tb_aes_encrypt_core;
  localparam logic [127:0] Pt    = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] Key4  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [191:0] Key6  = 192'h17161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [255:0] Key8  =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] Ct4   = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] Ct6   = 128'h91710deca070af6ee0df4c86a47ca9dd;
  localparam logic [127:0] Ct8   = 128'h8960494b9049fceabf456751cab7a28e;
  // FIPS-197 Appendix B vector, byte 0 in the LSBs.
  localparam logic [127:0] KeyB  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] PtB   = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] CtB   = 128'h320b6a19978511dcfb09dc021d842539;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  aes_encrypt_core_if #(.Nk(4)) if4 ();
  aes_encrypt_core_if #(.Nk(6)) if6 ();
  aes_encrypt_core_if #(.Nk(8)) if8 ();

`ifdef AES_ENC_BUSY_OUT_EN
  logic busy4, busy6, busy8;
  aes_encrypt_core #(.Nk(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4), .busy(busy4));
  aes_encrypt_core #(.Nk(6)) u_dut6 (.clk(clk), .rst(rst), .bus(if6), .busy(busy6));
  aes_encrypt_core #(.Nk(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8), .busy(busy8));
`else
  aes_encrypt_core #(.Nk(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  aes_encrypt_core #(.Nk(6)) u_dut6 (.clk(clk), .rst(rst), .bus(if6));
  aes_encrypt_core #(.Nk(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge; the next edge is the load edge.
  task automatic pulse(input bit l4, input bit l6, input bit l8);
    if4.load = l4;
    if6.load = l6;
    if8.load = l8;
    @(posedge clk);
    #1;
    if4.load = 1'b0;
    if6.load = 1'b0;
    if8.load = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    if4.load = 1'b0; if4.key = '0; if4.pt = '0;
    if6.load = 1'b0; if6.key = '0; if6.pt = '0;
    if8.load = 1'b0; if8.key = '0; if8.pt = '0;
    #1;
    chk("rst_ct4", if4.ct, 128'h0);
    chk("rst_ct6", if6.ct, 128'h0);
    chk("rst_ct8", if8.ct, 128'h0);
    chk("rst_v4", 128'(if4.ct_valid), 128'h0);
    chk("rst_v6", 128'(if6.ct_valid), 128'h0);
    chk("rst_v8", 128'(if8.ct_valid), 128'h0);
`ifdef AES_ENC_BUSY_OUT_EN
    chk("rst_busy4", 128'(busy4), 128'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // FIPS C.1/C.2/C.3 together, exact latency 51/59/67.
    if4.key = Key4; if4.pt = Pt;
    if6.key = Key6; if6.pt = Pt;
    if8.key = Key8; if8.pt = Pt;
    pulse(1'b1, 1'b1, 1'b1);
    for (int cyc = 1; cyc <= 67; cyc++) begin
      @(posedge clk);
      #1;
      chk("lat_v4", 128'(if4.ct_valid), 128'(cyc >= 51));
      chk("lat_v6", 128'(if6.ct_valid), 128'(cyc >= 59));
      chk("lat_v8", 128'(if8.ct_valid), 128'(cyc >= 67));
      chk("lat_ct4", if4.ct, (cyc >= 51) ? Ct4 : 128'h0);
      chk("lat_ct6", if6.ct, (cyc >= 59) ? Ct6 : 128'h0);
      chk("lat_ct8", if8.ct, (cyc >= 67) ? Ct8 : 128'h0);
`ifdef AES_ENC_BUSY_OUT_EN
      chk("busy4", 128'(busy4), 128'(cyc < 51));
      chk("busy8", 128'(busy8), 128'(cyc < 67));
`endif
    end

    // Reload while valid with the Appendix B vector: valid drops, old ct held.
    if4.key = KeyB; if4.pt = PtB;
    pulse(1'b1, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= 51; cyc++) begin
      @(posedge clk);
      #1;
      chk("rel_v4", 128'(if4.ct_valid), 128'(cyc >= 51));
      chk("rel_ct4", if4.ct, (cyc >= 51) ? CtB : Ct4);
    end
    chk("idle_v6", 128'(if6.ct_valid), 128'h1);
    chk("idle_ct6", if6.ct, Ct6);

    // Abort: start with C.1 key and B plaintext, restart with C.1 after 20 cycles.
    if4.key = Key4; if4.pt = PtB;
    pulse(1'b1, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #1;
      chk("abt1_v4", 128'(if4.ct_valid), 128'h0);
      chk("abt1_ct4", if4.ct, CtB);
    end
    if4.pt = Pt;
    pulse(1'b1, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= 51; cyc++) begin
      @(posedge clk);
      #1;
      chk("abt2_v4", 128'(if4.ct_valid), 128'(cyc >= 51));
      chk("abt2_ct4", if4.ct, (cyc >= 51) ? Ct4 : CtB);
    end

    // Reset in the middle of Nk=6 ROUND phase, then a clean rerun.
    pulse(1'b0, 1'b1, 1'b1);
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(posedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ct6", if6.ct, 128'h0);
    chk("mid_rst_v6", 128'(if6.ct_valid), 128'h0);
    chk("mid_rst_ct4", if4.ct, 128'h0);
    chk("mid_rst_v4", 128'(if4.ct_valid), 128'h0);
`ifdef AES_ENC_BUSY_OUT_EN
    chk("mid_rst_busy6", 128'(busy6), 128'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_v6", 128'(if6.ct_valid), 128'h0);
    pulse(1'b0, 1'b1, 1'b0);
    for (int cyc = 1; cyc <= 59; cyc++) begin
      // Inputs outside the load edge must be ignored.
      if (cyc == 1) begin
        if6.key = '1;
        if6.pt  = '1;
      end
      @(posedge clk);
      #1;
      chk("rerun_v6", 128'(if6.ct_valid), 128'(cyc >= 59));
      chk("rerun_ct6", if6.ct, (cyc >= 59) ? Ct6 : 128'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
